// File: rtl/dram_access_ctrl_pkg.sv
// Shared encodings for the DRAM access controller and its neighbours.
// Holds the FSM state encoding and the MDR load codes.
package dram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_HOLD = 2'd2,
        DONE       = 2'd3
    } dram_state_e;

    // MDR load codes, also decoded by the MDR and the control unit
    localparam logic [1:0] MDR_HOLD      = 2'b00;
    localparam logic [1:0] MDR_FROM_DRAM = 2'b01;
    localparam logic [1:0] MDR_FROM_BUS  = 2'b10;

    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/dram_access_ctrl_latency_counter.sv
// 4-bit load/decrement counter with zero flag; load wins over decrement.
// Decrement saturates at zero so a stray dec never wraps.
module dram_access_ctrl_latency_counter
    import dram_access_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dram_access_ctrl.sv
// Sequences single-byte reads/writes to a fixed-latency DRAM port; read done at T+READ_LATENCY+1,
// write done at T+WRITE_LATENCY+1. Requests are only sampled in IDLE; callers stall on busy.
module dram_access_ctrl
    import dram_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] MDR_to_DRAM,
    output logic [DATA_WIDTH-1:0] DRAM_to_MDR,
    output logic [1:0]            MDR_control_out,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [CNT_WIDTH-1:0] RD_LOAD = CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] WR_LOAD = CNT_WIDTH'(WRITE_LATENCY - 1);

    dram_state_e           state_q,     state_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q,    ram_we_d;
    logic [DATA_WIDTH-1:0] rdat_q,      rdat_d;
    logic                  rd_flag_q,   rd_flag_d;

    logic                  cnt_load;
    logic [CNT_WIDTH-1:0]  cnt_load_val;
    logic                  cnt_dec;
    logic                  cnt_zero;

    dram_access_ctrl_latency_counter u_lat_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = ram_we_q;
        rdat_d       = rdat_q;
        rd_flag_d    = rd_flag_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Read has priority; a simultaneous write is dropped
                if (rd_req) begin
                    ram_addr_d   = addr_in;
                    rd_flag_d    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = RD_LOAD;
                    state_d      = READ_WAIT;
                end else if (wr_req) begin
                    ram_addr_d   = addr_in;
                    ram_wdata_d  = MDR_to_DRAM;
                    ram_we_d     = 1'b1;
                    rd_flag_d    = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = WR_LOAD;
                    state_d      = WRITE_HOLD;
                end
            end
            READ_WAIT: begin
                if (cnt_zero) begin
                    rdat_d  = ram_rdata;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WRITE_HOLD: begin
                if (cnt_zero) begin
                    ram_we_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            rdat_q      <= '0;
            rd_flag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            rdat_q      <= rdat_d;
            rd_flag_q   <= rd_flag_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign MDR_control_out = ((state_q == DONE) && rd_flag_q) ? MDR_FROM_DRAM : MDR_HOLD;
    assign DRAM_to_MDR     = rdat_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign ram_we          = ram_we_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed bench for dram_access_ctrl: one instance with WRITE_LATENCY=1, one with WRITE_LATENCY=3.
module tb_dram_access_ctrl;

    logic        clock;
    logic        reset;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] addr_in;
    logic [7:0]  MDR_to_DRAM;
    logic [7:0]  ram_rdata;

    logic [7:0]  d2m_a,  d2m_b;
    logic [1:0]  mdr_a,  mdr_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic [15:0] raddr_a, raddr_b;
    logic [7:0]  wdat_a, wdat_b;
    logic        we_a,   we_b;

    int n_checks = 0;
    int n_fail   = 0;

    dram_access_ctrl #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(2), .WRITE_LATENCY(1)
    ) dut (
        .clock(clock), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
        .addr_in(addr_in), .MDR_to_DRAM(MDR_to_DRAM), .DRAM_to_MDR(d2m_a),
        .MDR_control_out(mdr_a), .busy(busy_a), .done(done_a),
        .ram_addr(raddr_a), .ram_wdata(wdat_a), .ram_we(we_a), .ram_rdata(ram_rdata)
    );

    dram_access_ctrl #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(2), .WRITE_LATENCY(3)
    ) dut3 (
        .clock(clock), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
        .addr_in(addr_in), .MDR_to_DRAM(MDR_to_DRAM), .DRAM_to_MDR(d2m_b),
        .MDR_control_out(mdr_b), .busy(busy_b), .done(done_b),
        .ram_addr(raddr_b), .ram_wdata(wdat_b), .ram_we(we_b), .ram_rdata(ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle; the cycle after edge T is called T+1
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [9:0] dmask;
        logic [9:0] bmask;
        int         ndone;
        int         nwe;

        reset       = 1'b1;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        addr_in     = 16'h0000;
        MDR_to_DRAM = 8'h00;
        ram_rdata   = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_we",   32'(we_a),   32'd0);
        chk("rst_mdr",  32'(mdr_a),  32'd0);
        chk("rst_d2m",  32'(d2m_a),  32'h00);
        chk("rst_addr", 32'(raddr_a), 32'h0000);
        chk("rst_busy3", 32'(busy_b), 32'd0);

        // Read 0x1234 -> 0xA5
        addr_in   = 16'h1234;
        ram_rdata = 8'hA5;
        rd_req    = 1'b1;
        tick();
        rd_req  = 1'b0;
        addr_in = 16'hFFFF;
        chk("rd_t1_addr", 32'(raddr_a), 32'h1234);
        chk("rd_t1_busy", 32'(busy_a), 32'd1);
        chk("rd_t1_done", 32'(done_a), 32'd0);
        tick();
        chk("rd_t2_addr", 32'(raddr_a), 32'h1234);
        chk("rd_t2_done", 32'(done_a), 32'd0);
        chk("rd_t2_mdr",  32'(mdr_a),  32'd0);
        tick();
        chk("rd_t3_done", 32'(done_a), 32'd1);
        chk("rd_t3_busy", 32'(busy_a), 32'd1);
        chk("rd_t3_mdr",  32'(mdr_a),  32'd1);
        chk("rd_t3_d2m",  32'(d2m_a),  32'hA5);
        ram_rdata = 8'h00;
        tick();
        chk("rd_t4_done", 32'(done_a), 32'd0);
        chk("rd_t4_mdr",  32'(mdr_a),  32'd0);
        chk("rd_t4_busy", 32'(busy_a), 32'd0);
        chk("rd_t4_d2m",  32'(d2m_a),  32'hA5);
        tick();

        // Write 0x3C to 0x00FF
        addr_in     = 16'h00FF;
        MDR_to_DRAM = 8'h3C;
        wr_req      = 1'b1;
        tick();
        wr_req      = 1'b0;
        MDR_to_DRAM = 8'h99;
        chk("wr_t1_we",    32'(we_a),    32'd1);
        chk("wr_t1_wdat",  32'(wdat_a),  32'h3C);
        chk("wr_t1_addr",  32'(raddr_a), 32'h00FF);
        chk("wr_t1_done",  32'(done_a),  32'd0);
        chk("wr3_t1_we",   32'(we_b),    32'd1);
        tick();
        chk("wr_t2_we",    32'(we_a),    32'd0);
        chk("wr_t2_done",  32'(done_a),  32'd1);
        chk("wr_t2_mdr",   32'(mdr_a),   32'd0);
        chk("wr_t2_d2m",   32'(d2m_a),   32'hA5);
        chk("wr3_t2_wdat", 32'(wdat_b),  32'h3C);
        tick();
        chk("wr_t3_busy",  32'(busy_a),  32'd0);
        chk("wr3_t3_we",   32'(we_b),    32'd1);
        chk("wr3_t3_done", 32'(done_b),  32'd0);
        tick();
        chk("wr3_t4_we",   32'(we_b),    32'd0);
        chk("wr3_t4_done", 32'(done_b),  32'd1);
        tick();
        tick();

        // Simultaneous read and write: read wins
        addr_in   = 16'h0010;
        ram_rdata = 8'h5A;
        rd_req    = 1'b1;
        wr_req    = 1'b1;
        tick();
        rd_req = 1'b0;
        wr_req = 1'b0;
        chk("both_addr", 32'(raddr_a), 32'h0010);
        ndone = 0;
        nwe   = 0;
        for (int i = 1; i <= 5; i++) begin
            if (done_a) ndone++;
            if (we_a)   nwe++;
            if (i < 5) tick();
        end
        chk("both_ndone", 32'(ndone), 32'd1);
        chk("both_nwe",   32'(nwe),   32'd0);
        chk("both_d2m",   32'(d2m_a), 32'h5A);
        tick();

        // rd_req held high: accepted again only in the IDLE cycle after done
        addr_in   = 16'h0200;
        ram_rdata = 8'h77;
        rd_req    = 1'b1;
        dmask     = '0;
        bmask     = '0;
        tick();
        for (int i = 1; i <= 9; i++) begin
            dmask[i] = done_a;
            bmask[i] = busy_a;
            tick();
        end
        rd_req = 1'b0;
        chk("held_done_mask", 32'(dmask), 32'(10'b0010001000));
        chk("held_busy_mask", 32'(bmask), 32'(10'b1011101110));
        for (int i = 0; i < 5; i++) tick();
        chk("held_idle", 32'(busy_a), 32'd0);

        // Reset during a 3-cycle write hold
        addr_in     = 16'h0ABC;
        MDR_to_DRAM = 8'h11;
        wr_req      = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("rstw_t1_we", 32'(we_b), 32'd1);
        tick();
        chk("rstw_t2_we", 32'(we_b), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_we",   32'(we_b),   32'd0);
        chk("rstw_busy", 32'(busy_b), 32'd0);
        chk("rstw_done", 32'(done_b), 32'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_b) ndone++;
        end
        chk("rstw_no_done", 32'(ndone), 32'd0);

        addr_in   = 16'h4321;
        ram_rdata = 8'hC3;
        rd_req    = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("post_rst_addr", 32'(raddr_b), 32'h4321);
        tick();
        chk("post_rst_t2_done", 32'(done_b), 32'd0);
        tick();
        chk("post_rst_done", 32'(done_b), 32'd1);
        chk("post_rst_mdr",  32'(mdr_b),  32'd1);
        chk("post_rst_d2m",  32'(d2m_b),  32'hC3);
        tick();
        chk("post_rst_idle", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
- Sequences single-byte reads and writes between the processor datapath and the DRAM image store, using a fixed-latency synchronous RAM port.
- Captures the address from AR and write data from MDR_to_DRAM.
- Returns read data on DRAM_to_MDR and generates the MDR load code, so MDR latches the byte in the cycle after done.
- Sits between AR/MDR and the DRAM macro; the control unit stalls on busy.

Parameters:
- ADDR_WIDTH, 16, DRAM byte address width (256x256 image).
- DATA_WIDTH, 8, byte width; matches the MDR.
- READ_LATENCY, 2, cycles from ram_addr valid to ram_rdata valid; legal range 1..15.
- WRITE_LATENCY, 1, cycles ram_we is held per write; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- rd_req  in  1  read request; sampled only in IDLE.
- wr_req  in  1  write request; sampled only in IDLE.
- addr_in  in  ADDR_WIDTH  address from AR.
- MDR_to_DRAM  in  DATA_WIDTH  write data from MDR.
- DRAM_to_MDR  out  DATA_WIDTH  registered read data to MDR.
- MDR_control_out  out  2  2'b01 for one cycle when read data is ready, else 2'b00.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse for reads and writes.
- ram_addr  out  ADDR_WIDTH  registered DRAM address.
- ram_wdata  out  DATA_WIDTH  registered DRAM write data.
- ram_we  out  1  DRAM write enable.
- ram_rdata  in  DATA_WIDTH  DRAM read data.

Behaviour:
- One clock (clock). Reset is synchronous, active-high, and overrides everything.
- Reset values: state IDLE; busy, done, ram_we = 0; MDR_control_out = 2'b00; DRAM_to_MDR, ram_addr, ram_wdata = 0; latency counter = 0.
- States: IDLE, READ_WAIT, WRITE_HOLD, DONE.
- IDLE:
  - rd_req=1 on edge T: ram_addr <= addr_in; cnt <= READ_LATENCY-1; go READ_WAIT.
  - Else wr_req=1: ram_addr <= addr_in; ram_wdata <= MDR_to_DRAM; ram_we <= 1; cnt <= WRITE_LATENCY-1; go WRITE_HOLD.
  - Simultaneous rd_req and wr_req: read wins; the write is dropped, not queued.
- READ_WAIT:
  - cnt>0: decrement.
  - cnt==0: DRAM_to_MDR <= ram_rdata; go DONE with read flag set.
- WRITE_HOLD:
  - ram_we stays 1; ram_addr and ram_wdata stay stable.
  - cnt>0: decrement.
  - cnt==0: ram_we <= 0; go DONE with read flag clear.
- DONE: lasts exactly 1 cycle.
  - done=1 and busy=1.
  - MDR_control_out=2'b01 only if the read flag is set.
  - Next state is IDLE. A request present in this cycle is ignored; it is accepted on the next cycle, in IDLE.
- Latency, counted from the edge that samples the request:
  - Read: done is high in cycle T+READ_LATENCY+1.
  - Write: ram_we is high for exactly WRITE_LATENCY cycles starting at T+1; done is high in cycle T+WRITE_LATENCY+1.
- DRAM_to_MDR holds its value until the next read capture; writes never change it.
- Requests arriving while busy=1 are ignored. Requesters hold rd_req/wr_req until they see busy or done.
- addr_in and MDR_to_DRAM are sampled only at acceptance; later changes have no effect on the transaction in flight.
- Reset mid-operation: ram_we drops on that edge, no done is issued, and the transaction is abandoned.
- Address wrap is the caller's concern; ram_addr is passed through unmodified.

Decomposition:
- Shared package (or include file):
  - State encoding constants IDLE=2'd0, READ_WAIT=2'd1, WRITE_HOLD=2'd2, DONE=2'd3.
  - MDR control codes MDR_HOLD=2'b00, MDR_FROM_DRAM=2'b01, MDR_FROM_BUS=2'b10, shared with MDR and the control unit.
- One sub-module, latency_counter: a 4-bit load/decrement counter with a zero flag, reused by the read and write paths.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, ram_we=0, MDR_control_out=00, DRAM_to_MDR=0x00.
- Read at addr_in=0x1234, RAM returns 0xA5, READ_LATENCY=2 -> ram_addr=0x1234 from T+1; done and MDR_control_out=01 in cycle T+3 only; DRAM_to_MDR=0xA5 held afterwards.
- Write 0x3C to 0x00FF, WRITE_LATENCY=1 -> ram_we=1 only in cycle T+1 with ram_wdata=0x3C; done in T+2; MDR_control_out stays 00; DRAM_to_MDR unchanged.
- rd_req and wr_req both high at 0x0010 -> read executes; ram_we never asserts; one done pulse.
- Second rd_req held high through busy and DONE -> accepted only in the IDLE cycle after done; back-to-back reads complete every READ_LATENCY+2 cycles.
- Reset asserted during WRITE_HOLD with WRITE_LATENCY=3 -> ram_we=0 on the next edge, no done, state IDLE; a new read then completes normally.
